// File: rtl/booth_multiplier.sv
// Signed 32x32 -> 64-bit radix-4 Booth multiplier, two-stage pipeline.
// Stage 1 registers the operands; stage 2 registers the Booth-recoded sum.
module booth_multiplier (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic [63:0] product,
  output logic        out_valid
);

  logic [31:0] r_m;
  logic [31:0] r_q;
  logic        r_v1;

  logic [32:0] w_qext;
  logic [63:0] w_mext;
  logic [63:0] w_m2ext;
  logic [63:0] w_mneg;
  logic [63:0] w_m2neg;
  logic [63:0] w_pp;
  logic [63:0] w_sum;

  assign w_qext  = {r_q, 1'b0};
  assign w_mext  = {{32{r_m[31]}}, r_m};
  assign w_m2ext = {w_mext[62:0], 1'b0};
  assign w_mneg  = ~w_mext + 64'd1;
  assign w_m2neg = ~w_m2ext + 64'd1;

  // Operands and their tag are captured every edge; in_valid never stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m  <= '0;
      r_q  <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_m  <= multiplicand;
      r_q  <= multiplier;
      r_v1 <= in_valid;
    end
  end

  // Each overlapping triplet of {Q,0} picks one of 0, +-M, +-2M at weight 4^i.
  always_comb begin
    w_sum = '0;
    w_pp  = '0;
    for (int i = 0; i < 16; i++) begin
      case (w_qext[2*i +: 3])
        3'b001, 3'b010: w_pp = w_mext;
        3'b011:         w_pp = w_m2ext;
        3'b100:         w_pp = w_m2neg;
        3'b101, 3'b110: w_pp = w_mneg;
        default:        w_pp = '0;
      endcase
      w_sum = w_sum + (w_pp << (2 * i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      product   <= w_sum;
      out_valid <= r_v1;
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed vector table, random
// back-to-back stream, valid toggling and reset in the middle of the pipe.
module tb_booth_multiplier;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [63:0] product;
  logic        out_valid;

  int checks;
  int errors;

  // Expected contents of the two pipeline stages as the bench sees them.
  logic [63:0] expProd [2];
  logic        expValid [2];

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [14];

  booth_multiplier dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] refMul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic checkOutput(input string name);
    checks++;
    if (out_valid !== expValid[1]) begin
      errors++;
      $display("[TB] FAIL %s out_valid: got %0b want %0b", name, out_valid, expValid[1]);
    end
    checks++;
    if (product !== expProd[1]) begin
      errors++;
      $display("[TB] FAIL %s product: got %h want %h", name, product, expProd[1]);
    end
  endtask

  // Drives one operand pair, advances one edge, updates the stage model, checks.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic v, input logic [63:0] exp,
                               input string name);
    multiplicand = a;
    multiplier   = b;
    in_valid     = v;
    @(posedge clk);
    #1;
    if (!reset_n) begin
      expProd[0]  = '0;
      expProd[1]  = '0;
      expValid[0] = 1'b0;
      expValid[1] = 1'b0;
    end else begin
      expProd[1]  = expProd[0];
      expValid[1] = expValid[0];
      expProd[0]  = exp;
      expValid[0] = v;
    end
    checkOutput(name);
  endtask

  task automatic clearModel();
    expProd[0]  = '0;
    expProd[1]  = '0;
    expValid[0] = 1'b0;
    expValid[1] = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rv;

    checks = 0;
    errors = 0;
    clearModel();

    vecs[0]  = '{"zero_zero",  32'h0000_0000, 32'h0000_0000, 64'h0000_0000_0000_0000};
    vecs[1]  = '{"p5_p3",      32'h0000_0005, 32'h0000_0003, 64'h0000_0000_0000_000F};
    vecs[2]  = '{"m4_p6",      32'hFFFF_FFFC, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFE8};
    vecs[3]  = '{"p7_m2",      32'h0000_0007, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2};
    vecs[4]  = '{"m8_m3",      32'hFFFF_FFF8, 32'hFFFF_FFFD, 64'h0000_0000_0000_0018};
    vecs[5]  = '{"min_min",    32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[6]  = '{"max_max",    32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    vecs[7]  = '{"min_max",    32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
    vecs[8]  = '{"m1_m1",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[9]  = '{"booth_aaaa", 32'h1234_5678, 32'hAAAA_AAAA, refMul(32'h1234_5678, 32'hAAAA_AAAA)};
    vecs[10] = '{"booth_5555", 32'h1234_5678, 32'h5555_5555, refMul(32'h1234_5678, 32'h5555_5555)};
    vecs[11] = '{"q_all_ones", 32'h1234_5678, 32'hFFFF_FFFF, 64'hFFFF_FFFF_EDCB_A988};
    vecs[12] = '{"zero_right", 32'hDEAD_BEEF, 32'h0000_0000, 64'h0000_0000_0000_0000};
    vecs[13] = '{"zero_left",  32'h0000_0000, 32'hCAFE_F00D, 64'h0000_0000_0000_0000};

    // Asynchronous reset with nonzero operands: outputs clear without an edge.
    reset_n      = 1'b1;
    in_valid     = 1'b1;
    multiplicand = 32'h1234_5678;
    multiplier   = 32'h0000_0003;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("reset_async");
    for (int i = 0; i < 3; i++)
      applyStimulus(32'h1234_5678, 32'h0000_0003, 1'b1, 64'd0, "reset_hold");

    // Release away from the rising edge; the first pair is captured next edge.
    reset_n = 1'b1;
    for (int i = 0; i < 14; i++)
      applyStimulus(vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp, vecs[i].name);
    applyStimulus(32'h0, 32'h0, 1'b0, 64'd0, "drain0");
    applyStimulus(32'h0, 32'h0, 1'b0, 64'd0, "drain1");

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      applyStimulus(ra, rb, 1'b1, refMul(ra, rb), "random_b2b");
    end

    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      rv = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rv, refMul(ra, rb), "random_valid");
    end

    // Two results in flight, then reset lands between edges.
    applyStimulus(32'h0000_0011, 32'h0000_0022, 1'b1, refMul(32'h11, 32'h22), "pre_reset0");
    applyStimulus(32'h0000_0033, 32'h0000_0044, 1'b1, refMul(32'h33, 32'h44), "pre_reset1");
    #2;
    reset_n = 1'b0;
    #1;
    clearModel();
    checkOutput("reset_mid");
    applyStimulus(32'h0000_0055, 32'h0000_0066, 1'b1, 64'd0, "reset_mid_hold");
    reset_n = 1'b1;
    applyStimulus(32'hFFFF_FFF9, 32'h0000_0009, 1'b1, 64'hFFFF_FFFF_FFFF_FFC1, "post_reset0");
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b0, 64'd0, "post_reset1");
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b0, 64'd0, "post_reset2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
